// File: rtl/multicycle_alu.sv
// ---------------------------------------------------------------------------
// multicycle_alu
//
// Clocked execute-stage ALU with a configurable datapath width. It uses the
// same 4-bit operation encoding as the combinational 16-bit ALU it replaces.
// Rotates, shifts, logic ops and add/sub finish in one cycle. Multiply
// (shift-add) and divide (restoring) run iteratively over WIDTH cycles. A
// start/busy/done handshake lets the EX stage stall on the long operations.
//
// Build option:
//   ALU_MULDIV_EN  When defined, the MUL/DIV engines, the iteration counter
//                  and the RUN state are compiled in. When undefined, opcodes
//                  1 and 2 decode as NOP and busy is tied low.
//
// Parameters:
//   WIDTH          operand/result width, 4..64 (default 16)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          request, sampled on a rising edge when not busy
//   CTRL[3:0]      opcode, sampled with start
//   MUX_intop      operand A, sampled with start
//   MUX_inbottom   operand B / shift amount, sampled with start
//   busy           iterative operation in progress (RUN state)
//   done           one-cycle pulse; results valid and held from this cycle on
//   ALU_Result     registered result
//   Remainder      registered divide remainder / multiply high half
//   Overflow_flag  registered overflow flag
//
// Opcodes: 1 MUL, 2 DIV, 8 ROL, 9 ROR, 10 SLL, 11 SLR, 12 OR, 13 AND,
//          14 SUB, 15 ADD; 0 and 3..7 are NOP (done pulses, outputs held).
// ---------------------------------------------------------------------------
module multicycle_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       CTRL,
    input  logic [WIDTH-1:0] MUX_intop,
    input  logic [WIDTH-1:0] MUX_inbottom,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [WIDTH-1:0] Remainder,
    output logic             Overflow_flag
);

    // -----------------------------------------------------------------------
    // Opcodes
    // -----------------------------------------------------------------------
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd2;
`endif
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_SLL = 4'd10;
    localparam logic [3:0] OP_SLR = 4'd11;
    localparam logic [3:0] OP_OR  = 4'd12;
    localparam logic [3:0] OP_AND = 4'd13;
    localparam logic [3:0] OP_SUB = 4'd14;
    localparam logic [3:0] OP_ADD = 4'd15;

    // WIDTH expressed at operand width, so shift amounts compare cleanly.
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // -----------------------------------------------------------------------
    // Signed overflow detection for add and subtract
    // -----------------------------------------------------------------------
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        // Like-signed operands producing a result of the other sign.
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] d);
        // Unlike-signed operands producing a result with the sign of b.
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // -----------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs while start is
    // sampled
    // -----------------------------------------------------------------------
    logic signed [WIDTH-1:0] op_a_s;
    logic signed [WIDTH-1:0] op_b_s;
    logic signed [WIDTH-1:0] sum_s;
    logic signed [WIDTH-1:0] diff_s;
    logic        [WIDTH-1:0] rot_amt;
    logic        [WIDTH-1:0] sc_res;
    logic                    sc_ovf;
    logic                    sc_wr;

    assign op_a_s  = signed'(MUX_intop);
    assign op_b_s  = signed'(MUX_inbottom);
    assign sum_s   = op_a_s + op_b_s;
    assign diff_s  = op_a_s - op_b_s;
    assign rot_amt = MUX_inbottom % W_VAL;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_wr  = 1'b1;
        case (CTRL)
            // A rotate amount of 0 gives a complementary shift of WIDTH,
            // which yields zero, so the OR leaves A unchanged.
            OP_ROL: sc_res = (MUX_intop << rot_amt) | (MUX_intop >> (W_VAL - rot_amt));
            OP_ROR: sc_res = (MUX_intop >> rot_amt) | (MUX_intop << (W_VAL - rot_amt));
            OP_SLL: begin
                if (MUX_inbottom >= W_VAL) begin
                    sc_res = '0;
                    sc_ovf = |MUX_intop;
                end else begin
                    sc_res = MUX_intop << MUX_inbottom;
                    // Bits pushed out the top are those above WIDTH-B.
                    sc_ovf = |(MUX_intop >> (W_VAL - MUX_inbottom));
                end
            end
            OP_SLR: begin
                if (MUX_inbottom >= W_VAL) begin
                    sc_res = '0;
                end else begin
                    sc_res = MUX_intop >> MUX_inbottom;
                end
            end
            OP_OR:  sc_res = MUX_intop | MUX_inbottom;
            OP_AND: sc_res = MUX_intop & MUX_inbottom;
            OP_SUB: begin
                sc_res = diff_s;
                sc_ovf = sub_ovf(op_a_s, op_b_s, diff_s);
            end
            OP_ADD: begin
                sc_res = sum_s;
                sc_ovf = add_ovf(op_a_s, op_b_s, sum_s);
            end
            // NOP and (when the engines are absent) MUL/DIV: leave outputs.
            default: sc_wr = 1'b0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // -----------------------------------------------------------------------
    // Iterative MUL/DIV engine
    //
    // eng_op holds the multiplicand (MUL) or divisor (DIV).
    // MUL: {eng_hi, eng_lo} starts as {0, B}; each step adds eng_op into the
    //      high half when lo[0] is set and shifts the pair right one place.
    // DIV: eng_lo starts as A and shifts left, collecting quotient bits;
    //      eng_hi is the partial remainder. With a zero divisor every trial
    //      subtraction succeeds, which naturally gives an all-ones quotient
    //      and a remainder equal to A.
    // -----------------------------------------------------------------------
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] eng_op;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;
    logic             eng_div;
    logic             is_muldiv;
    logic             launch;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    assign is_muldiv = (CTRL == OP_MUL) || (CTRL == OP_DIV);
    assign launch    = (state != RUN) && start && is_muldiv;

    always_comb begin
        mul_sum   = {1'b0, eng_hi} + (eng_lo[0] ? {1'b0, eng_op} : '0);
        div_shift = {eng_hi, eng_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, eng_op});
        // When div_ge holds the true difference is below the divisor, so
        // the low WIDTH bits carry it exactly.
        div_sub   = div_shift[WIDTH-1:0] - eng_op;
        if (eng_div) begin
            hi_nxt = div_ge ? div_sub : div_shift[WIDTH-1:0];
            lo_nxt = {eng_lo[WIDTH-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], eng_lo[WIDTH-1:1]};
        end
    end

    // Operand/working registers: captured at launch, so later input
    // changes cannot disturb a running operation.
    always_ff @(posedge clk) begin
        if (launch) begin
            eng_div <= (CTRL == OP_DIV);
            eng_hi  <= '0;
            if (CTRL == OP_DIV) begin
                eng_op <= MUX_inbottom;
                eng_lo <= MUX_intop;
            end else begin
                eng_op <= MUX_intop;
                eng_lo <= MUX_inbottom;
            end
        end else if (state == RUN) begin
            eng_hi <= hi_nxt;
            eng_lo <= lo_nxt;
        end
    end

    assign busy = (state == RUN);
`else
    assign busy = 1'b0;
`endif

    assign done = (state == DONE);

    // -----------------------------------------------------------------------
    // Control FSM and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ALU_Result    <= '0;
            Remainder     <= '0;
            Overflow_flag <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt           <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
`ifdef ALU_MULDIV_EN
                        if (is_muldiv) begin
                            cnt   <= CNT_W'(WIDTH);
                            state <= RUN;
                        end else
`endif
                        begin
                            if (sc_wr) begin
                                ALU_Result    <= sc_res;
                                Remainder     <= '0;
                                Overflow_flag <= sc_ovf;
                            end
                            state <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
`ifdef ALU_MULDIV_EN
                    // The last iteration lands here; publish its result
                    // directly so done follows the final step.
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        ALU_Result    <= lo_nxt;
                        Remainder     <= hi_nxt;
                        Overflow_flag <= eng_div ? ~|eng_op : |hi_nxt;
                        state         <= DONE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_alu
//
// Self-checking bench for multicycle_alu (WIDTH=16). A table of
// {opcode, operands, expected outputs} is applied in order; expectations are
// queued when a request is driven and compared when done appears. Extra
// sequences cover back-to-back ops, start ignored during RUN and reset in
// the middle of an operation. Expectations follow ALU_MULDIV_EN: without it,
// MUL/DIV behave as NOP.
// ---------------------------------------------------------------------------
module tb_multicycle_alu;

    localparam int WIDTH = 16;
`ifdef ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam int MD_LAT = MD_EN ? WIDTH + 1 : 1;

    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd2;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_SLL = 4'd10;
    localparam logic [3:0] OP_SLR = 4'd11;
    localparam logic [3:0] OP_OR  = 4'd12;
    localparam logic [3:0] OP_AND = 4'd13;
    localparam logic [3:0] OP_SUB = 4'd14;
    localparam logic [3:0] OP_ADD = 4'd15;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       ctrl  = 4'd0;
    logic [WIDTH-1:0] opa   = '0;
    logic [WIDTH-1:0] opb   = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] remainder;
    logic             overflow_flag;

    multicycle_alu #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .CTRL         (ctrl),
        .MUX_intop    (opa),
        .MUX_inbottom (opb),
        .busy         (busy),
        .done         (done),
        .ALU_Result   (alu_result),
        .Remainder    (remainder),
        .Overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] rem;
        logic             ovf;
        bit               hold;
        int               lat;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] rem;
        logic             ovf;
        int               lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] last_res = '0;
    logic [WIDTH-1:0] last_rem = '0;
    logic             last_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] rem, input logic ovf,
                       input bit hold, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.rem = rem; v.ovf = ovf;
        v.hold = hold; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Queue the expected outputs; a held (NOP) entry repeats the last result.
    task automatic push_exp(input vec_t v);
        exp_t e;
        if (v.hold) begin
            e.res = last_res; e.rem = last_rem; e.ovf = last_ovf;
        end else begin
            e.res = v.res; e.rem = v.rem; e.ovf = v.ovf;
        end
        e.lat    = v.lat;
        last_res = e.res;
        last_rem = e.rem;
        last_ovf = e.ovf;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        int   n;
        int   nb;
        push_exp(v);
        @(negedge clk);
        start = 1'b1; ctrl = v.op; opa = v.a; opb = v.b;
        @(posedge clk); #1;
        // Scramble the inputs once sampled; results must not depend on them.
        start = 1'b0; ctrl = OP_ADD; opa = ~v.a; opb = ~v.b;
        n  = 1;
        nb = 0;
        while (!done && n <= 40) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: done not seen after %0d cycles, required within %0d", name, n, e.lat);
        end else begin
            check($sformatf("%s.res", name), 64'(alu_result), 64'(e.res));
            check($sformatf("%s.rem", name), 64'(remainder), 64'(e.rem));
            check($sformatf("%s.ovf", name), 64'(overflow_flag), 64'(e.ovf));
            check($sformatf("%s.latency", name), 64'(n), 64'(e.lat));
            check($sformatf("%s.busy_cycles", name), 64'(nb), 64'(e.lat - 1));
            check($sformatf("%s.busy_at_done", name), 64'(busy), 64'(0));
        end
        @(posedge clk); #1;
        check($sformatf("%s.done_pulse", name), 64'(done), 64'(0));
    endtask

    // start held high across DONE: two single-cycle ops on consecutive edges.
    task automatic b2b_seq();
        vec_t v1;
        vec_t v2;
        exp_t e;
        v1.op = OP_ADD; v1.a = 16'd5; v1.b = 16'd6; v1.res = 16'd11;
        v1.rem = '0; v1.ovf = 1'b0; v1.hold = 1'b0; v1.lat = 1;
        v2.op = OP_SUB; v2.a = 16'd3; v2.b = 16'd5; v2.res = 16'hFFFE;
        v2.rem = '0; v2.ovf = 1'b0; v2.hold = 1'b0; v2.lat = 1;
        push_exp(v1);
        push_exp(v2);
        @(negedge clk);
        start = 1'b1; ctrl = v1.op; opa = v1.a; opb = v1.b;
        @(posedge clk); #1;
        check("b2b.done1", 64'(done), 64'(1));
        e = sb.pop_front();
        check("b2b.res1", 64'(alu_result), 64'(e.res));
        check("b2b.ovf1", 64'(overflow_flag), 64'(e.ovf));
        @(negedge clk);
        ctrl = v2.op; opa = v2.a; opb = v2.b;
        @(posedge clk); #1;
        check("b2b.done2", 64'(done), 64'(1));
        e = sb.pop_front();
        check("b2b.res2", 64'(alu_result), 64'(e.res));
        check("b2b.ovf2", 64'(overflow_flag), 64'(e.ovf));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b.done_low", 64'(done), 64'(0));
    endtask

`ifdef ALU_MULDIV_EN
    // An ADD request pulsed during a MUL is dropped; the MUL result arrives
    // on schedule and no second done follows.
    task automatic ignored_start_seq();
        vec_t v;
        exp_t e;
        int   n;
        v.op = OP_MUL; v.a = 16'd1000; v.b = 16'd50; v.res = 16'd50000;
        v.rem = '0; v.ovf = 1'b0; v.hold = 1'b0; v.lat = WIDTH + 1;
        push_exp(v);
        @(negedge clk);
        start = 1'b1; ctrl = v.op; opa = v.a; opb = v.b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n <= 40) begin
            @(negedge clk);
            if (n == 4) begin
                start = 1'b1; ctrl = OP_ADD; opa = 16'd1; opb = 16'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        e = sb.pop_front();
        check("ign.latency", 64'(n), 64'(e.lat));
        check("ign.res", 64'(alu_result), 64'(e.res));
        check("ign.rem", 64'(remainder), 64'(e.rem));
        @(posedge clk); #1;
        check("ign.no_extra_done", 64'(done), 64'(0));
    endtask
`endif

    // Reset during cycle 8 of a DIV: outputs clear at once, no done follows,
    // and the next request is handled normally.
    task automatic reset_seq();
        vec_t v;
        int   nd;
        @(negedge clk);
        start = 1'b1; ctrl = OP_DIV; opa = 16'd1000; opb = 16'd50;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.res", 64'(alu_result), 64'(0));
        check("rst_mid.rem", 64'(remainder), 64'(0));
        check("rst_mid.ovf", 64'(overflow_flag), 64'(0));
        check("rst_mid.busy", 64'(busy), 64'(0));
        check("rst_mid.done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0; last_rem = '0; last_ovf = 1'b0;
        nd = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("rst_mid.no_done", 64'(nd), 64'(0));
        v.op = OP_ADD; v.a = 16'd2; v.b = 16'd3; v.res = 16'd5;
        v.rem = '0; v.ovf = 1'b0; v.hold = 1'b0; v.lat = 1;
        run_vec(v, "post_rst_add");
    endtask

    initial begin
        // opcode, A, B, result, remainder, overflow, hold, latency
        add(OP_MUL, 16'd1000,  16'd50,    16'd50000, 16'd0,     1'b0, !MD_EN, MD_LAT);
        add(OP_DIV, 16'd1000,  16'd50,    16'd20,    16'd0,     1'b0, !MD_EN, MD_LAT);
        add(OP_DIV, 16'd1000,  16'd0,     16'hFFFF,  16'd1000,  1'b1, !MD_EN, MD_LAT);
        add(OP_MUL, 16'd300,   16'd300,   16'h5F90,  16'h0001,  1'b1, !MD_EN, MD_LAT);
        add(OP_SLL, 16'd32000, 16'd5,     16'hA000,  16'd0,     1'b1, 1'b0,   1);
        add(OP_ROL, 16'd1000,  16'd50,    16'h0FA0,  16'd0,     1'b0, 1'b0,   1);
        add(OP_ADD, 16'h7FFF,  16'd1,     16'h8000,  16'd0,     1'b1, 1'b0,   1);
        add(OP_SUB, 16'd1000,  16'd50,    16'd950,   16'd0,     1'b0, 1'b0,   1);
        add(4'd0,   16'd1234,  16'd5678,  16'd0,     16'd0,     1'b0, 1'b1,   1);
        add(OP_ROR, 16'h0001,  16'd1,     16'h8000,  16'd0,     1'b0, 1'b0,   1);
        add(OP_SLL, 16'h0001,  16'd16,    16'h0000,  16'd0,     1'b1, 1'b0,   1);
        add(OP_SLL, 16'h0000,  16'd20,    16'h0000,  16'd0,     1'b0, 1'b0,   1);
        add(OP_DIV, 16'd7,     16'd3,     16'd2,     16'd1,     1'b0, !MD_EN, MD_LAT);
        add(OP_SLR, 16'h8000,  16'd15,    16'h0001,  16'd0,     1'b0, 1'b0,   1);
        add(OP_SLR, 16'hFFFF,  16'd16,    16'h0000,  16'd0,     1'b0, 1'b0,   1);
        add(OP_OR,  16'hF0F0,  16'h0F00,  16'hFFF0,  16'd0,     1'b0, 1'b0,   1);
        add(OP_AND, 16'hF0F0,  16'h0FF0,  16'h00F0,  16'd0,     1'b0, 1'b0,   1);
        add(OP_SUB, 16'h8000,  16'd1,     16'h7FFF,  16'd0,     1'b1, 1'b0,   1);
        add(4'd5,   16'hAAAA,  16'h5555,  16'd0,     16'd0,     1'b0, 1'b1,   1);
        add(OP_ADD, 16'hFFFF,  16'd1,     16'h0000,  16'd0,     1'b0, 1'b0,   1);
        add(OP_ROL, 16'h8001,  16'd17,    16'h0003,  16'd0,     1'b0, 1'b0,   1);
        add(OP_ROL, 16'h1234,  16'd0,     16'h1234,  16'd0,     1'b0, 1'b0,   1);
        add(OP_MUL, 16'hFFFF,  16'hFFFF,  16'h0001,  16'hFFFE,  1'b1, !MD_EN, MD_LAT);
        add(OP_DIV, 16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0, !MD_EN, MD_LAT);
        add(OP_DIV, 16'hFFFF,  16'h8000,  16'h0001,  16'h7FFF,  1'b0, !MD_EN, MD_LAT);
        add(4'd7,   16'h0F0F,  16'h0003,  16'd0,     16'd0,     1'b0, 1'b1,   1);

        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.res", 64'(alu_result), 64'(0));
        check("reset.rem", 64'(remainder), 64'(0));
        check("reset.ovf", 64'(overflow_flag), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        b2b_seq();
`ifdef ALU_MULDIV_EN
        ignored_start_seq();
`endif
        reset_seq();

        check("scoreboard.empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
